// File: rtl/socket_fifo.sv
// ============================================================================
// socket_fifo : single-clock FIFO between chain stages with socket-ready flag.
// Optional sticky overflow/underflow outputs: define SOCKET_FIFO_ERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module socket_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int SOCKET_SIZE = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_dv,
   input  logic                          i_rd_en,
   output logic [DATA_WIDTH-1:0]         o_data,
   output logic                          o_dv,
   output logic                          o_empty,
   output logic                          o_full,
   output logic                          o_sock_rdy,
   output logic [$clog2(DEPTH+1)-1:0]    o_count
`ifdef SOCKET_FIFO_ERR_EN
   ,
   output logic                          o_ovf,
   output logic                          o_udf
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_SOCK  = CNT_W'(SOCKET_SIZE);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;
   logic [DATA_WIDTH-1:0] data_q,   data_d;
   logic                  dv_q,     dv_d;

   logic                  rd_acc;
   logic                  wr_acc;

   // Flags come straight from the registered count so they never glitch on inputs.
   assign o_empty    = (count_q == '0);
   assign o_full     = (count_q == CNT_FULL);
   assign o_sock_rdy = (count_q >= CNT_SOCK);
   assign o_count    = count_q;
   assign o_data     = data_q;
   assign o_dv       = dv_q;

   assign rd_acc = i_rd_en && !o_empty;
   assign wr_acc = i_dv && (!o_full || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_d   = data_q;
      dv_d     = 1'b0;

      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end

      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         data_d   = mem_q[rd_ptr_q];
         dv_d     = 1'b1;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         dv_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         dv_q     <= dv_d;
      end
   end

   // Storage has no reset; writes are suppressed while reset is asserted.
   always_ff @(posedge i_clk) begin
      if (i_rst && wr_acc) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

`ifdef SOCKET_FIFO_ERR_EN
   logic ovf_q;
   logic udf_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (i_dv && !wr_acc) ovf_q <= 1'b1;
         if (i_rd_en && o_empty) udf_q <= 1'b1;
      end
   end

   assign o_ovf = ovf_q;
   assign o_udf = udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_socket_fifo.sv
// ============================================================================
// tb_socket_fifo : randomized + directed scoreboard bench for socket_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_socket_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int SOCK  = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_dv = 1'b0;
   logic          i_rd_en = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_dv;
   logic          o_empty;
   logic          o_full;
   logic          o_sock_rdy;
   logic [CW-1:0] o_count;
`ifdef SOCKET_FIFO_ERR_EN
   logic          o_ovf;
   logic          o_udf;
`endif

   socket_fifo #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .SOCKET_SIZE (SOCK)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_data     (i_data),
      .i_dv       (i_dv),
      .i_rd_en    (i_rd_en),
      .o_data     (o_data),
      .o_dv       (o_dv),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_sock_rdy (o_sock_rdy),
      .o_count    (o_count)
`ifdef SOCKET_FIFO_ERR_EN
      ,
      .o_ovf      (o_ovf),
      .o_udf      (o_udf)
`endif
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Reference model: contents as a queue, plus what the read port should show.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] sb[$];
   logic          exp_dv   = 1'b0;
   logic [DW-1:0] exp_data = '0;
   logic          exp_ovf  = 1'b0;
   logic          exp_udf  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   always @(posedge i_clk) begin
      bit rd_acc, wr_acc;
      if (!i_rst) begin
         mq.delete();
         sb.delete();
         exp_dv   = 1'b0;
         exp_data = '0;
         exp_ovf  = 1'b0;
         exp_udf  = 1'b0;
      end else begin
         rd_acc = i_rd_en && (mq.size() != 0);
         wr_acc = i_dv && ((mq.size() < DEPTH) || rd_acc);
         if (i_dv && !wr_acc)              exp_ovf = 1'b1;
         if (i_rd_en && mq.size() == 0)    exp_udf = 1'b1;
         exp_dv = rd_acc;
         if (rd_acc) begin
            exp_data = mq.pop_front();
            sb.push_back(exp_data);
         end
         if (wr_acc) mq.push_back(i_data);
      end
   end

   always @(negedge i_clk) begin
      logic [DW-1:0] want;
      if (mon_en) begin
         check("count",    int'(o_count),    mq.size());
         check("empty",    int'(o_empty),    int'(mq.size() == 0));
         check("full",     int'(o_full),     int'(mq.size() == DEPTH));
         check("sock_rdy", int'(o_sock_rdy), int'(mq.size() >= SOCK));
         check("dv",       int'(o_dv),       int'(exp_dv));
         check("data_hold", int'(o_data),    int'(exp_data));
`ifdef SOCKET_FIFO_ERR_EN
         check("ovf",      int'(o_ovf),      int'(exp_ovf));
         check("udf",      int'(o_udf),      int'(exp_udf));
`endif
         if (o_dv === 1'b1) begin
            if (sb.size() == 0) begin
               check("sb_underrun", 1, 0);
            end else begin
               want = sb.pop_front();
               check("sb_data", int'(o_data), int'(want));
            end
         end
      end
   end

   task automatic step(input logic dv, input logic [DW-1:0] d, input logic rd, input logic rstn);
      i_dv    = dv;
      i_data  = d;
      i_rd_en = rd;
      i_rst   = rstn;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      // Reset held with both requests active.
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      mon_en = 1'b1;
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_count", int'(o_count), 0);
      check("rst_data",  int'(o_data),  0);

      // Fill, overflow attempt, drain.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
      check("fill_full", int'(o_full), 1);
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("drain_empty", int'(o_empty), 1);

      // Simultaneous at full.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b1);
      step(1'b1, 8'h55, 1'b1, 1'b1);
      check("full_both_count", int'(o_count), DEPTH);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous at empty: no write-through.
      step(1'b1, 8'h33, 1'b1, 1'b1);
      check("empty_both_dv",    int'(o_dv),    0);
      check("empty_both_count", int'(o_count), 1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("empty_both_data",  int'(o_data),  8'h33);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Wrap-around streaming with 3 words of prefill.
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, DW'(8'h90 + i), 1'b1, 1'b1);
         check("stream_dv", int'(o_dv), 1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset mid-operation with 7 words stored and a read pending.
      for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("midrst_count", int'(o_count), 0);
      check("midrst_dv",    int'(o_dv),    0);
      step(1'b1, 8'h7E, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("midrst_data", int'(o_data), 8'h7E);

      // Randomized traffic with rare resets.
      for (int i = 0; i < 3000; i++) begin
         logic dv, rd, rstn;
         int   phase;
         phase = (i / 250) % 3;
         dv    = ($urandom_range(0, 99) < (phase == 0 ? 75 : (phase == 1 ? 30 : 55)));
         rd    = ($urandom_range(0, 99) < (phase == 0 ? 30 : (phase == 1 ? 75 : 55)));
         rstn  = ($urandom_range(0, 299) != 0);
         step(dv, DW'($urandom), rd, rstn);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/socket_fifo.md
Name: socket_fifo

Overview:
- Synchronous single-clock FIFO placed between two processing modules in the chain.
- Write side takes the upstream module's o_data/o_dv.
- Read side feeds the downstream module's i_data/i_dv/i_empty/i_full and is popped by that module's o_rd_en.
- Also reports whether a full socket (SOCKET_SIZE words) is buffered, so the downstream socket controller can start a burst.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 16, storage words; must be >= 2 and >= SOCKET_SIZE; need not be a power of two.
- SOCKET_SIZE, 4, words per socket; threshold for o_sock_rdy.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous and active-low.
- i_data  in  DATA_WIDTH  write data from the upstream module.
- i_dv  in  1  write request, qualifies i_data.
- i_rd_en  in  1  read request from the downstream module's o_rd_en.
- o_data  out  DATA_WIDTH  read data, registered.
- o_dv  out  1  o_data valid; one-cycle pulse per accepted read.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_sock_rdy  out  1  count >= SOCKET_SIZE.
- o_count  out  $clog2(DEPTH+1)  words currently stored.

Behaviour:
- Reset (i_rst == 0 at a rising edge):
  - wr_ptr = rd_ptr = count = 0.
  - o_data = 0, o_dv = 0, o_empty = 1, o_full = 0, o_sock_rdy = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all buffered words; any read accepted in the reset cycle is dropped and o_dv is 0 the next cycle.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = i_rd_en && !o_empty.
  - wr_acc = i_dv && (!o_full || rd_acc).
- Write:
  - On wr_acc, mem[wr_ptr] <= i_data.
  - wr_ptr wraps from DEPTH-1 to 0.
- Read:
  - On rd_acc, o_data <= mem[rd_ptr] and o_dv <= 1 at the same edge.
  - Latency: data visible the cycle after i_rd_en is asserted.
  - rd_ptr wraps from DEPTH-1 to 0.
  - o_dv <= 0 when no read is accepted; o_data holds its last value.
- Count:
  - count += 1 on wr only; count -= 1 on rd only; unchanged on both or neither.
  - All flags derive combinationally from the registered count.
- Boundary conditions:
  - Empty with simultaneous write and read: write accepted, read rejected. No write-through; the word is readable the following cycle.
  - Full with simultaneous write and read: both accepted, count stays DEPTH.
  - Full with write only: write dropped, storage unchanged.
  - Empty with read only: ignored, o_dv = 0.
- Ordering: strict FIFO order; no word duplicated or lost except dropped overflow writes.

Optional Feature:
- Macro: SOCKET_FIFO_ERR_EN.
- When defined, adds two outputs:
  - o_ovf: sticky; set when i_dv && !wr_acc.
  - o_udf: sticky; set when i_rd_en && o_empty.
  - Both cleared only by reset; both reset to 0.
- When not defined, the ports and logic are absent; the overflow/underflow behaviour above is unchanged (silently dropped).

Test Plan:
- Reset check: hold i_rst = 0 for 3 cycles with i_dv = 1 and i_rd_en = 1 -> o_empty = 1, o_count = 0, o_dv = 0, o_data = 0 throughout; o_sock_rdy = 0.
- Fill then drain (DEPTH = 16, SOCKET_SIZE = 4):
  - Write 0x00..0x0F -> o_sock_rdy rises after the 4th write, o_full = 1 after the 16th.
  - 17th write 0xAA dropped (o_ovf = 1 if SOCKET_FIFO_ERR_EN).
  - Read 16 -> o_data 0x00..0x0F in order, each the cycle after its i_rd_en; o_empty = 1 after the last.
- Simultaneous at full: full FIFO, i_dv = 1 with 0x55 and i_rd_en = 1 -> o_count stays 16; 0x55 emerges as the 16th subsequent read.
- Simultaneous at empty: empty FIFO, i_dv = 1 with 0x33 and i_rd_en = 1 -> o_dv = 0 next cycle, o_count = 1; next i_rd_en returns 0x33.
- Wrap-around: 40 words streamed with continuous write and read after 3 words of prefill -> output sequence exactly matches input, o_count held at 3, no o_dv gaps.
- Reset mid-operation: with 7 words stored, pulse i_rst low 1 cycle -> o_count = 0, o_empty = 1; subsequent write 0x7E then read returns 0x7E.
